conv_pool_sat: RTL

CONV_POOL_SAT -- requirements
Module: conv_pool_sat

---
 rtl/conv_pool_sat_pkg.sv | 16 +
 rtl/conv_pool_sat_if.sv | 18 +
 rtl/conv_pool_sat_fifo.sv | 39 +++
 rtl/conv_pool_sat.sv | 75 +++++++
 4 files changed

// File: rtl/conv_pool_sat_pkg.sv
// Shared types and saturation limits for the convolver max-pool stage.
package conv_pkg;
  localparam int Y_W = 21;
  localparam int Z_W = 8;
  localparam int Z_MIN = -128;
  localparam int Z_MAX = 127;

  typedef logic signed [Y_W-1:0] y_t;
  typedef logic signed [Z_W-1:0] z_t;

  function automatic z_t sat_z(input y_t v);
    if (v > y_t'(Z_MAX)) return z_t'(Z_MAX);
    if (v < y_t'(Z_MIN)) return z_t'(Z_MIN);
    return z_t'(v);
  endfunction
endpackage

// File: rtl/conv_pool_sat_if.sv
// Sample-in / result-out valid-ready bundle for conv_pool_sat.
interface conv_pool_sat_if;
  conv_pkg::y_t s_data_in_y;
  logic         s_valid_y;
  logic         s_ready_y;
  conv_pkg::z_t m_data_out_z;
  logic         m_valid_z;
  logic         m_ready_z;

  modport slave (
    input  s_data_in_y, s_valid_y, m_ready_z,
    output s_ready_y, m_data_out_z, m_valid_z
  );
  modport master (
    output s_data_in_y, s_valid_y, m_ready_z,
    input  s_ready_y, m_data_out_z, m_valid_z
  );
endinterface

// File: rtl/conv_pool_sat_fifo.sv
// Two-entry result FIFO; a push is ignored when full, a pop when empty.
module pool_out_fifo import conv_pkg::*; (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  z_t   din_i,
  input  logic pop_i,
  output z_t   dout_o,
  output logic full_o,
  output logic empty_o
);
  z_t         mem_q [2];
  logic       wp_q, rp_q;
  logic [1:0] cnt_q;
  logic       do_push, do_pop;

  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rp_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wp_q     <= 1'b0;
      rp_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wp_q] <= din_i;
        wp_q        <= !wp_q;
      end
      if (do_pop) rp_q <= !rp_q;
      cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end
endmodule

// File: rtl/conv_pool_sat.sv
// Max-pool over POOL-sample windows (truncated at frame end), shift, saturate to 8 bits.
// Define CONV_POOL_RELU_EN to clamp negative pooled maxima to zero.
module conv_pool_sat import conv_pkg::*; #(
  parameter int FRAME_LEN = 97,
  parameter int POOL      = 4,
  parameter int SHIFT     = 8
) (
  input logic            clk,
  input logic            reset,
  conv_pool_sat_if.slave bus
);
  localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  logic [2:0]    win_q, win_d;
  logic [FW-1:0] frm_q, frm_d;
  y_t            max_q, max_d, cur_max, pooled;
  logic          rdy_q, full, empty, accept, close, frm_last, push;
  z_t            res;

  // rdy_q keeps s_ready_y low through reset and rises on the first edge after it
  assign bus.s_ready_y = rdy_q && !full;
  assign bus.m_valid_z = !empty;
  assign accept        = bus.s_valid_y && bus.s_ready_y;
  assign frm_last      = (frm_q == FW'(FRAME_LEN - 1));
  assign close         = (win_q == 3'(POOL - 1)) || frm_last;

  always_comb begin
    cur_max = bus.s_data_in_y;
    if (win_q != 3'd0 && max_q > bus.s_data_in_y) cur_max = max_q;
`ifdef CONV_POOL_RELU_EN
    pooled = cur_max[Y_W-1] ? '0 : cur_max;
`else
    pooled = cur_max;
`endif
    res = sat_z(pooled >>> SHIFT);
  end

  always_comb begin
    win_d = win_q;
    frm_d = frm_q;
    max_d = max_q;
    push  = 1'b0;
    if (accept) begin
      max_d = cur_max;
      push  = close;
      win_d = close ? 3'd0 : win_q + 3'd1;
      frm_d = frm_last ? '0 : frm_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_q <= '0;
      frm_q <= '0;
      max_q <= '0;
      rdy_q <= 1'b0;
    end else begin
      win_q <= win_d;
      frm_q <= frm_d;
      max_q <= max_d;
      rdy_q <= 1'b1;
    end
  end

  pool_out_fifo u_fifo (
    .clk     (clk),
    .rst     (reset),
    .push_i  (push),
    .din_i   (res),
    .pop_i   (bus.m_valid_z && bus.m_ready_z),
    .dout_o  (bus.m_data_out_z),
    .full_o  (full),
    .empty_o (empty)
  );
endmodule
